// File: rtl/disp_scan_driver.sv
// disp_scan_driver: 8-digit common-anode 7-seg scan driver with a double-buffered frame. Optional macro DISP_LZ_BLANK_EN.
// Latency: AN/SEG/SEG_DP/FRAME_SYNC registered, one CLK after the DISP_CE edge; LOAD_ACK one CLK after LOAD.
// Backpressure: none; LOAD is always accepted and a later LOAD overwrites pending data not yet shown.
module disp_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int SLOT_TICKS  = 8,
  parameter int BLANK_TICKS = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DISP_CE,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  LOAD,
  output logic                  LOAD_ACK,
  output logic                  PENDING,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            SEG,
  output logic                  SEG_DP,
  output logic                  FRAME_SYNC
);

  localparam int PW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam int DW = $clog2(DIGITS);
  localparam logic [PW-1:0] PH_BLANK = PW'(BLANK_TICKS);
  localparam logic [PW-1:0] PH_LAST  = PW'(SLOT_TICKS - 1);
  localparam logic [DW-1:0] D_LAST   = DW'(DIGITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_ON} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         d_q, d_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic                  swap;
  logic [4*DIGITS-1:0]   act_dat_q, act_dat_d, pend_dat_q, pend_dat_d;
  logic [DIGITS-1:0]     act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                  pending_q, pending_d;
  logic                  load_ack_q, frame_sync_q;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic [3:0]            nib;

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    case (v)
      4'h0: hex_font = 7'h40;  4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;  4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;  4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;  4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;  4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;  4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;  4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;  default: hex_font = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      d_q          <= '0;
      phase_q      <= '0;
      act_dat_q    <= '0;
      act_dp_q     <= '0;
      pend_dat_q   <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_sync_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      seg_dp_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      d_q          <= d_d;
      phase_q      <= phase_d;
      act_dat_q    <= act_dat_d;
      act_dp_q     <= act_dp_d;
      pend_dat_q   <= pend_dat_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      load_ack_q   <= LOAD;
      frame_sync_q <= swap;
      an_q         <= an_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    phase_d = phase_q;
    swap    = 1'b0;
    if (DISP_CE) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          d_d     = '0;
          phase_d = '0;
          swap    = 1'b1;
        end
        ST_BLANK: begin
          phase_d = phase_q + 1'b1;
          if (phase_d == PH_BLANK) state_d = ST_ON;
        end
        ST_ON: begin
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            state_d = ST_BLANK;
            if (d_q == D_LAST) begin
              d_d  = '0;
              swap = 1'b1;
            end else begin
              d_d = d_q + 1'b1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The swap consumes the pre-edge pending copy; a coincident LOAD refills it.
    act_dat_d  = act_dat_q;
    act_dp_d   = act_dp_q;
    if (swap && pending_q) begin
      act_dat_d = pend_dat_q;
      act_dp_d  = pend_dp_q;
    end
    pend_dat_d = LOAD ? DATA : pend_dat_q;
    pend_dp_d  = LOAD ? DP   : pend_dp_q;
    pending_d  = LOAD ? 1'b1 : (swap ? 1'b0 : pending_q);
  end

`ifdef DISP_LZ_BLANK_EN
  logic [DIGITS-1:0] lz_mask;
  logic              lz_run;
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run & (act_dat_q[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_run;
    end
  end
`endif

  always_comb begin
    an_d     = '1;
    seg_d    = 7'h7F;
    seg_dp_d = 1'b1;
    nib      = act_dat_q[4*d_d +: 4];
    if (state_d == ST_ON) begin
      an_d[d_d] = 1'b0;
      seg_d     = hex_font(nib);
      seg_dp_d  = ~act_dp_q[d_d];
`ifdef DISP_LZ_BLANK_EN
      if (lz_mask[d_d]) seg_d = 7'h7F;
`endif
    end
  end

  assign LOAD_ACK   = load_ack_q;
  assign PENDING    = pending_q;
  assign AN         = an_q;
  assign SEG        = seg_q;
  assign SEG_DP     = seg_dp_q;
  assign FRAME_SYNC = frame_sync_q;

endmodule
